// File: rtl/pipeline_stage_regs.sv
// Pipeline registers for PC, IF/ID and ID/EX with hazard-unit stall/flush control.
// Also keeps saturating stall/flush statistics and a stall watchdog.
//
// Ports:
//   clk, rst           rising-edge clock, async active-high reset
//   stall_F, stall_D   1 = advance/load, 0 = hold (PC, IF/ID)
//   flush_D, flush_E   1 = load bubble into IF/ID, ID/EX
//   pc_load, pc_target PC redirect (branch taken / return)
//   instr_F            instruction at pc_F
//   ctrl_D, rs/rt/rd_D decode outputs carried into ID/EX
//   pc_F               fetch address
//   instr_D, pc_plus1_D, valid_D          IF/ID contents
//   ctrl_E, rs/rt/rd_E, pc_plus1_E, valid_E  ID/EX contents
//   stall_cycles, flush_count             saturating statistics
//   hazard_timeout     sticky: PC frozen for MAX_STALL cycles
module pipeline_stage_regs #(
  parameter logic [7:0] RESET_PC  = 8'h00,
  parameter logic [7:0] NOP_INSTR = 8'h00,
  parameter int         CTRL_W    = 12,
  parameter int         CNT_W     = 16,
  parameter int         MAX_STALL = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_F,
  input  logic              stall_D,
  input  logic              flush_D,
  input  logic              flush_E,
  input  logic              pc_load,
  input  logic [7:0]        pc_target,
  input  logic [7:0]        instr_F,
  input  logic [CTRL_W-1:0] ctrl_D,
  input  logic [1:0]        rs_D,
  input  logic [1:0]        rt_D,
  input  logic [1:0]        rd_D,
  output logic [7:0]        pc_F,
  output logic [7:0]        instr_D,
  output logic [7:0]        pc_plus1_D,
  output logic              valid_D,
  output logic [CTRL_W-1:0] ctrl_E,
  output logic [1:0]        rs_E,
  output logic [1:0]        rt_E,
  output logic [1:0]        rd_E,
  output logic [7:0]        pc_plus1_E,
  output logic              valid_E,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count,
  output logic              hazard_timeout
);

  localparam int RUN_W = $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

  logic [RUN_W-1:0] run_cnt;
  logic             frozen;

  // PC is frozen only when not stalled-open and not redirected
  assign frozen = !stall_F && !pc_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_F <= RESET_PC;
    end else if (pc_load) begin
      pc_F <= pc_target;
    end else if (stall_F) begin
      pc_F <= pc_F + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_D    <= NOP_INSTR;
      pc_plus1_D <= 8'h00;
      valid_D    <= 1'b0;
    end else if (flush_D) begin
      instr_D    <= NOP_INSTR;
      pc_plus1_D <= 8'h00;
      valid_D    <= 1'b0;
    end else if (stall_D) begin
      instr_D    <= instr_F;
      pc_plus1_D <= pc_F + 8'd1;
      valid_D    <= 1'b1;
    end
  end

  // A zeroed bundle clears reg_write/mem_read, so bubbles
  // never forward or trigger load-use stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_E     <= '0;
      rs_E       <= 2'b00;
      rt_E       <= 2'b00;
      rd_E       <= 2'b00;
      pc_plus1_E <= 8'h00;
      valid_E    <= 1'b0;
    end else if (flush_E) begin
      ctrl_E     <= '0;
      rs_E       <= 2'b00;
      rt_E       <= 2'b00;
      rd_E       <= 2'b00;
      pc_plus1_E <= 8'h00;
      valid_E    <= 1'b0;
    end else begin
      ctrl_E     <= ctrl_D;
      rs_E       <= rs_D;
      rt_E       <= rt_D;
      rd_E       <= rd_D;
      pc_plus1_E <= pc_plus1_D;
      valid_E    <= valid_D;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!stall_F && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if ((flush_D || flush_E) && flush_count != '1)
        flush_count <= flush_count + 1'b1;
    end
  end

  // Flag is raised on the edge where the run count
  // becomes MAX_STALL; run count saturates there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt        <= '0;
      hazard_timeout <= 1'b0;
    end else if (frozen) begin
      if (run_cnt != RUN_MAX)
        run_cnt <= run_cnt + 1'b1;
      if (run_cnt >= RUN_MAX - 1'b1)
        hazard_timeout <= 1'b1;
    end else begin
      run_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_pipeline_stage_regs.sv
// Scoreboard bench for pipeline_stage_regs.
// Directed vectors push expected state; a monitor pops and compares.
module tb_pipeline_stage_regs;

  logic        clk;
  logic        rst;
  logic        stall_F, stall_D, flush_D, flush_E, pc_load;
  logic [7:0]  pc_target, instr_F;
  logic [11:0] ctrl_D;
  logic [1:0]  rs_D, rt_D, rd_D;
  logic [7:0]  pc_F, instr_D, pc_plus1_D, pc_plus1_E;
  logic        valid_D, valid_E, hazard_timeout;
  logic [11:0] ctrl_E;
  logic [1:0]  rs_E, rt_E, rd_E;
  logic [3:0]  stall_cycles, flush_count;

  pipeline_stage_regs #(
    .RESET_PC (8'h00),
    .NOP_INSTR(8'h00),
    .CTRL_W   (12),
    .CNT_W    (4),
    .MAX_STALL(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_F       (stall_F),
    .stall_D       (stall_D),
    .flush_D       (flush_D),
    .flush_E       (flush_E),
    .pc_load       (pc_load),
    .pc_target     (pc_target),
    .instr_F       (instr_F),
    .ctrl_D        (ctrl_D),
    .rs_D          (rs_D),
    .rt_D          (rt_D),
    .rd_D          (rd_D),
    .pc_F          (pc_F),
    .instr_D       (instr_D),
    .pc_plus1_D    (pc_plus1_D),
    .valid_D       (valid_D),
    .ctrl_E        (ctrl_E),
    .rs_E          (rs_E),
    .rt_E          (rt_E),
    .rd_E          (rd_E),
    .pc_plus1_E    (pc_plus1_E),
    .valid_E       (valid_E),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count),
    .hazard_timeout(hazard_timeout)
  );

  // Instruction memory image: word at address a is A0+a
  assign instr_F = 8'hA0 + pc_F;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [7:0]  pc;
    logic [7:0]  id;
    logic [7:0]  ppd;
    logic        vd;
    logic [11:0] ce;
    logic [1:0]  rs;
    logic [1:0]  rt;
    logic [1:0]  rd;
    logic [7:0]  ppe;
    logic        ve;
    logic [3:0]  sc;
    logic [3:0]  fc;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   k = 0;

  // ke = vector index whose decode fields reached ID/EX, 0 = bubble
  function automatic exp_t mk(input logic [7:0] pc, id, ppd,
                              input logic vd, input int ke,
                              input logic [7:0] ppe, input logic ve,
                              input logic [3:0] sc, fc, input logic to);
    exp_t e;
    e.pc  = pc;
    e.id  = id;
    e.ppd = ppd;
    e.vd  = vd;
    e.ppe = ppe;
    e.ve  = ve;
    e.sc  = sc;
    e.fc  = fc;
    e.to  = to;
    if (ke == 0) begin
      e.ce = 12'h000;
      e.rs = 2'b00;
      e.rt = 2'b00;
      e.rd = 2'b00;
    end else begin
      e.ce = 12'h800 + 12'(ke);
      e.rs = 2'(ke) ^ 2'b01;
      e.rt = 2'(ke) ^ 2'b10;
      e.rd = 2'(ke);
    end
    return e;
  endfunction

  task automatic vec(input logic sf, sd, fd, fe, ld,
                     input logic [7:0] tgt, input exp_t e);
    @(negedge clk);
    k++;
    stall_F   = sf;
    stall_D   = sd;
    flush_D   = fd;
    flush_E   = fe;
    pc_load   = ld;
    pc_target = tgt;
    ctrl_D    = 12'h800 + 12'(k);
    rs_D      = 2'(k) ^ 2'b01;
    rt_D      = 2'(k) ^ 2'b10;
    rd_D      = 2'(k);
    sb.push_back(e);
  endtask

  task automatic free_run(input exp_t e);
    vec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, e);
  endtask

  // Monitor: compare after each clock edge or reset assertion
  initial begin
    exp_t e;
    exp_t a;
    int   idx;
    idx = 0;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = '{pc_F, instr_D, pc_plus1_D, valid_D, ctrl_E, rs_E, rt_E,
              rd_E, pc_plus1_E, valid_E, stall_cycles, flush_count,
              hazard_timeout};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL chk%0d: got pc=%h iD=%h ppD=%h vD=%b cE=%h rs=%h rt=%h rd=%h ppE=%h vE=%b sc=%h fc=%h to=%b / want pc=%h iD=%h ppD=%h vD=%b cE=%h rs=%h rt=%h rd=%h ppE=%h vE=%b sc=%h fc=%h to=%b",
                   idx, a.pc, a.id, a.ppd, a.vd, a.ce, a.rs, a.rt, a.rd,
                   a.ppe, a.ve, a.sc, a.fc, a.to, e.pc, e.id, e.ppd,
                   e.vd, e.ce, e.rs, e.rt, e.rd, e.ppe, e.ve, e.sc,
                   e.fc, e.to);
        end
        idx++;
      end
    end
  end

  initial begin
    exp_t rst_e;
    rst_e     = mk(8'h00, 8'h00, 8'h00, 1'b0, 0, 8'h00, 1'b0,
                   4'h0, 4'h0, 1'b0);
    rst       = 1'b0;
    stall_F   = 1'b1;
    stall_D   = 1'b1;
    flush_D   = 1'b0;
    flush_E   = 1'b0;
    pc_load   = 1'b0;
    pc_target = 8'h00;
    ctrl_D    = 12'h000;
    rs_D      = 2'b00;
    rt_D      = 2'b00;
    rd_D      = 2'b00;
    sb.push_back(rst_e);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Free run
    free_run(mk(8'h01, 8'hA0, 8'h01, 1, 1, 8'h00, 0, 4'h0, 4'h0, 0));
    free_run(mk(8'h02, 8'hA1, 8'h02, 1, 2, 8'h01, 1, 4'h0, 4'h0, 0));
    free_run(mk(8'h03, 8'hA2, 8'h03, 1, 3, 8'h02, 1, 4'h0, 4'h0, 0));
    free_run(mk(8'h04, 8'hA3, 8'h04, 1, 4, 8'h03, 1, 4'h0, 4'h0, 0));
    free_run(mk(8'h05, 8'hA4, 8'h05, 1, 5, 8'h04, 1, 4'h0, 4'h0, 0));

    // Load-use bubble at pc 5
    vec(0, 0, 0, 1, 0, 8'h00,
        mk(8'h05, 8'hA4, 8'h05, 1, 0, 8'h00, 0, 4'h1, 4'h1, 0));
    free_run(mk(8'h06, 8'hA5, 8'h06, 1, 7, 8'h05, 1, 4'h1, 4'h1, 0));

    // Taken branch to 40
    vec(1, 1, 1, 1, 1, 8'h40,
        mk(8'h40, 8'h00, 8'h00, 0, 0, 8'h00, 0, 4'h1, 4'h2, 0));
    free_run(mk(8'h41, 8'hE0, 8'h41, 1, 9, 8'h00, 0, 4'h1, 4'h2, 0));

    // RET: three frozen cycles, then redirect to 12
    vec(0, 0, 1, 0, 0, 8'h00,
        mk(8'h41, 8'h00, 8'h00, 0, 10, 8'h41, 1, 4'h2, 4'h3, 0));
    vec(0, 0, 1, 0, 0, 8'h00,
        mk(8'h41, 8'h00, 8'h00, 0, 11, 8'h00, 0, 4'h3, 4'h4, 0));
    vec(0, 0, 1, 0, 0, 8'h00,
        mk(8'h41, 8'h00, 8'h00, 0, 12, 8'h00, 0, 4'h4, 4'h5, 0));
    vec(0, 0, 0, 0, 1, 8'h12,
        mk(8'h12, 8'h00, 8'h00, 0, 13, 8'h00, 0, 4'h5, 4'h5, 0));
    free_run(mk(8'h13, 8'hB2, 8'h13, 1, 14, 8'h00, 0, 4'h5, 4'h5, 0));
    free_run(mk(8'h14, 8'hB3, 8'h14, 1, 15, 8'h13, 1, 4'h5, 4'h5, 0));

    // PC wrap FF -> 00
    vec(1, 1, 0, 0, 1, 8'hFF,
        mk(8'hFF, 8'hB4, 8'h15, 1, 16, 8'h14, 1, 4'h5, 4'h5, 0));
    free_run(mk(8'h00, 8'h9F, 8'h00, 1, 17, 8'h15, 1, 4'h5, 4'h5, 0));
    free_run(mk(8'h01, 8'hA0, 8'h01, 1, 18, 8'h00, 1, 4'h5, 4'h5, 0));

    // 20 stalled cycles, pc_load keeps the watchdog clear
    for (int i = 0; i < 20; i++) begin
      vec(0, 0, 0, 0, 1, 8'h01,
          mk(8'h01, 8'hA0, 8'h01, 1, 19 + i, 8'h01, 1,
             (6 + i > 15) ? 4'hF : 4'(6 + i), 4'h5, 0));
    end

    // Watchdog trips on the 8th frozen cycle
    for (int i = 0; i < 8; i++) begin
      vec(0, 0, 0, 0, 0, 8'h00,
          mk(8'h01, 8'hA0, 8'h01, 1, 39 + i, 8'h01, 1, 4'hF, 4'h5,
             logic'(i == 7)));
    end
    free_run(mk(8'h02, 8'hA1, 8'h02, 1, 47, 8'h01, 1, 4'hF, 4'h5, 1));
    free_run(mk(8'h03, 8'hA2, 8'h03, 1, 48, 8'h02, 1, 4'hF, 4'h5, 1));
    free_run(mk(8'h04, 8'hA3, 8'h04, 1, 49, 8'h03, 1, 4'hF, 4'h5, 1));

    // Reset mid-cycle while stalled, then held across an edge
    @(negedge clk);
    stall_F = 1'b0;
    stall_D = 1'b0;
    sb.push_back(rst_e);
    #2 rst = 1'b1;
    @(negedge clk);
    stall_F = 1'b1;
    stall_D = 1'b1;
    sb.push_back(rst_e);
    @(posedge clk);
    #3 rst = 1'b0;
    free_run(mk(8'h01, 8'hA0, 8'h01, 1, 50, 8'h00, 0, 4'h0, 4'h0, 0));

    repeat (4) @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending / want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
